// File: rtl/control_sequencer.sv
// Mini-SRC control unit: a step counter T0..T7 plus the IR opcode select the datapath and ALU strobes.
// Latency: outputs decode the registered state combinationally. Each instruction takes 4..8 steps plus memory waits.
// Backpressure: memory steps stall while mem_ready is low. An optional wait limit halts the unit with mem_err.
module control_sequencer #(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  input  logic        Stop,
  output logic        AND,
  output logic        ANDI,
  output logic        OR,
  output logic        ORI,
  output logic        NOT,
  output logic        NEG,
  output logic        ADD,
  output logic        ADDI,
  output logic        SUB,
  output logic        MUL,
  output logic        DIV,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        ROR,
  output logic        ROL,
  output logic        BR,
  output logic        LD,
  output logic        LDI,
  output logic        ST,
  output logic        HALT,
  output logic        NOP,
  output logic        IncPC,
  output logic        PCout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        Cout,
  output logic        BAout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Run,
  output logic        illegal,
  output logic        mem_err
);

  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALTED = 4'd9
  } state_t;

  // Instruction classes sharing one step sequence
  typedef enum logic [3:0] {
    C_ALU3, C_IMM, C_UN, C_MD, C_LDI, C_LD, C_ST, C_BR, C_NOP, C_HALT, C_ILL
  } cls_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          err_set;
  logic [4:0]    opc;
  cls_t          cls;
  logic          op_en, is_end, mem_step, go_halt, go_t0, in_step;
  logic          unused_ir_bits;

  assign opc            = IR[31:27];
  assign cnt_inc        = cnt + CW'(1);
  assign unused_ir_bits = ^IR[26:0];

  // Group opcodes by the step sequence they follow
  always_comb begin
    cls = C_ILL;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  cls = C_ALU3;
      OP_ADDI, OP_ANDI, OP_ORI:         cls = C_IMM;
      OP_NOT, OP_NEG:                   cls = C_UN;
      OP_MUL, OP_DIV:                   cls = C_MD;
      OP_LDI:                           cls = C_LDI;
      OP_LD:                            cls = C_LD;
      OP_ST:                            cls = C_ST;
      OP_BR:                            cls = C_BR;
      OP_NOP:                           cls = C_NOP;
      OP_HALT:                          cls = C_HALT;
      default:                          cls = C_ILL;
    endcase
  end

  // State, wait counter and sticky memory error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_RST;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_err <= mem_err | err_set;
    end
  end

  // Strobe decode per step and opcode, then step sequencing
  always_comb begin
    {AND, ANDI, OR, ORI, NOT, NEG, ADD, ADDI, SUB, MUL, DIV} = '0;
    {SHR, SHRA, SHL, ROR, ROL, BR, LD, LDI, ST, HALT, NOP}   = '0;
    {IncPC, PCout, PCin, MARin, MDRin, MDRout, Read, Write}  = '0;
    {IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, CONin}   = '0;
    {Cout, BAout, Gra, Grb, Grc, Rin, Rout, illegal}         = '0;
    op_en     = 1'b0;
    is_end    = 1'b0;
    mem_step  = 1'b0;
    go_halt   = 1'b0;
    go_t0     = 1'b0;
    in_step   = 1'b1;
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;

    case (state)
      S_RST:    begin in_step = 1'b0; state_nxt = S_T0; end
      S_HALTED: in_step = 1'b0;
      S_T0:     begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1:     begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; mem_step = 1'b1; end
      S_T2:     begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          C_ALU3, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_UN:               begin Grb = 1'b1; Rout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
          C_MD:               begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_BR:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          C_NOP:              begin op_en = 1'b1; is_end = 1'b1; end
          C_HALT:             begin op_en = 1'b1; go_halt = 1'b1; end
          default:            begin illegal = 1'b1; go_t0 = 1'b1; end
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU3:                    begin Grc = 1'b1; Rout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
          C_IMM, C_LDI, C_LD, C_ST:  begin Cout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
          C_UN:                      begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; is_end = 1'b1; end
          C_MD:                      begin Grb = 1'b1; Rout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
          C_BR:                      begin PCout = 1'b1; Yin = 1'b1; end
          default:                   go_t0 = 1'b1;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU3, C_IMM, C_LDI:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; is_end = 1'b1; end
          C_MD:                  begin Zlowout = 1'b1; LOin = 1'b1; end
          C_LD, C_ST:            begin Zlowout = 1'b1; MARin = 1'b1; end
          C_BR:                  begin Cout = 1'b1; op_en = 1'b1; Zin = 1'b1; end
          default:               go_t0 = 1'b1;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MD:    begin Zhighout = 1'b1; HIin = 1'b1; is_end = 1'b1; end
          C_LD:    begin Read = 1'b1; MDRin = 1'b1; mem_step = 1'b1; end
          C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          C_BR:    begin Zlowout = 1'b1; PCin = 1'b1; is_end = 1'b1; end
          default: go_t0 = 1'b1;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; is_end = 1'b1; end
          C_ST:    begin MDRout = 1'b1; Write = 1'b1; mem_step = 1'b1; is_end = 1'b1; end
          default: go_t0 = 1'b1;
        endcase
      end
      default: begin in_step = 1'b0; state_nxt = S_RST; end
    endcase

    // The single op strobe follows the opcode in its op step
    if (op_en) begin
      case (opc)
        OP_LD:   LD   = 1'b1;
        OP_LDI:  LDI  = 1'b1;
        OP_ST:   ST   = 1'b1;
        OP_ADD:  ADD  = 1'b1;
        OP_SUB:  SUB  = 1'b1;
        OP_AND:  AND  = 1'b1;
        OP_OR:   OR   = 1'b1;
        OP_ROR:  ROR  = 1'b1;
        OP_ROL:  ROL  = 1'b1;
        OP_SHR:  SHR  = 1'b1;
        OP_SHRA: SHRA = 1'b1;
        OP_SHL:  SHL  = 1'b1;
        OP_ADDI: ADDI = 1'b1;
        OP_ANDI: ANDI = 1'b1;
        OP_ORI:  ORI  = 1'b1;
        OP_MUL:  MUL  = 1'b1;
        OP_DIV:  DIV  = 1'b1;
        OP_NEG:  NEG  = 1'b1;
        OP_NOT:  NOT  = 1'b1;
        OP_BR:   BR   = 1'b1;
        OP_NOP:  NOP  = 1'b1;
        OP_HALT: HALT = 1'b1;
        default: ;
      endcase
    end

    Run = in_step;

    // Memory steps hold until mem_ready; Stop only matters on an end step
    if (in_step) begin
      if (mem_step && !mem_ready) begin
        if (WAIT_LIMIT > 0 && cnt_inc == LIMIT) begin
          err_set   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_HALTED;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end else begin
        cnt_nxt = '0;
        if (go_halt)     state_nxt = S_HALTED;
        else if (go_t0)  state_nxt = S_T0;
        else if (is_end) state_nxt = Stop ? S_HALTED : S_T0;
        else             state_nxt = state_t'(state + 4'd1);
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  typedef logic [47:0] vec_t;
  typedef struct {
    vec_t        v;
    logic [31:0] ir;
    logic        rdy;
    logic        stop;
  } ent_t;

  localparam int I_AND = 0, I_ANDI = 1, I_OR = 2, I_ORI = 3, I_NOT = 4, I_NEG = 5;
  localparam int I_ADD = 6, I_ADDI = 7, I_SUB = 8, I_MUL = 9, I_DIV = 10, I_SHR = 11;
  localparam int I_SHRA = 12, I_SHL = 13, I_ROR = 14, I_ROL = 15, I_BR = 16, I_LD = 17;
  localparam int I_LDI = 18, I_ST = 19, I_HALT = 20, I_NOP = 21, I_INCPC = 22;
  localparam int I_PCOUT = 23, I_PCIN = 24, I_MARIN = 25, I_MDRIN = 26, I_MDROUT = 27;
  localparam int I_READ = 28, I_WRITE = 29, I_IRIN = 30, I_YIN = 31, I_ZIN = 32;
  localparam int I_ZLO = 33, I_ZHI = 34, I_HIIN = 35, I_LOIN = 36, I_CONIN = 37;
  localparam int I_COUT = 38, I_BAOUT = 39, I_GRA = 40, I_GRB = 41, I_GRC = 42;
  localparam int I_RIN = 43, I_ROUT = 44, I_RUN = 45, I_ILL = 46, I_MERR = 47;

  localparam logic [31:0] IR_ADD  = 32'h1800_0000;
  localparam logic [31:0] IR_SUB  = 32'h2000_0000;
  localparam logic [31:0] IR_MUL  = 32'h7800_0000;
  localparam logic [31:0] IR_LD   = 32'h0000_0000;
  localparam logic [31:0] IR_ST   = 32'h1000_0000;
  localparam logic [31:0] IR_BR   = 32'h9800_0000;
  localparam logic [31:0] IR_NOP  = 32'hD000_0000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_BAD  = 32'hF800_0000;

  logic clock, reset_n, mem_ready, Stop;
  logic [31:0] IR;
  logic AND, ANDI, OR, ORI, NOT, NEG, ADD, ADDI, SUB, MUL, DIV;
  logic SHR, SHRA, SHL, ROR, ROL, BR, LD, LDI, ST, HALT, NOP, IncPC;
  logic PCout, PCin, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout;
  logic Zhighout, HIin, LOin, CONin, Cout, BAout, Gra, Grb, Grc, Rin, Rout;
  logic Run, illegal, mem_err;
  vec_t obs;

  int checks = 0;
  int failures = 0;
  ent_t sb[$];

  control_sequencer #(.WAIT_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n), .IR(IR), .mem_ready(mem_ready), .Stop(Stop),
    .AND(AND), .ANDI(ANDI), .OR(OR), .ORI(ORI), .NOT(NOT), .NEG(NEG), .ADD(ADD),
    .ADDI(ADDI), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
    .ROR(ROR), .ROL(ROL), .BR(BR), .LD(LD), .LDI(LDI), .ST(ST), .HALT(HALT), .NOP(NOP),
    .IncPC(IncPC), .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .CONin(CONin),
    .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .Run(Run), .illegal(illegal), .mem_err(mem_err)
  );

  assign obs = {mem_err, illegal, Run, Rout, Rin, Grc, Grb, Gra, BAout, Cout, CONin,
                LOin, HIin, Zhighout, Zlowout, Zin, Yin, IRin, Write, Read, MDRout,
                MDRin, MARin, PCin, PCout, IncPC, NOP, HALT, ST, LDI, LD, BR, ROL, ROR,
                SHL, SHRA, SHR, DIV, MUL, SUB, ADDI, ADD, NEG, NOT, ORI, OR, ANDI, AND};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t b(input int i);
    return vec_t'(1) << i;
  endfunction

  // Queue one expected cycle plus the inputs to apply after sampling it
  task automatic push(input vec_t v, input logic [31:0] ir, input logic rdy, input logic stop);
    ent_t e;
    e.v = v; e.ir = ir; e.rdy = rdy; e.stop = stop;
    sb.push_back(e);
  endtask

  task automatic push_step(input vec_t v, input logic [31:0] ir, input logic rdy, input logic stop);
    push(v | b(I_RUN), ir, rdy, stop);
  endtask

  task automatic push_fetch(input logic [31:0] ir);
    push_step(b(I_PCOUT) | b(I_MARIN) | b(I_INCPC) | b(I_ZIN), ir, 1'b1, 1'b0);
    push_step(b(I_ZLO) | b(I_PCIN) | b(I_READ) | b(I_MDRIN), ir, 1'b1, 1'b0);
    push_step(b(I_MDROUT) | b(I_IRIN), ir, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected %h", obs, vec_t'(0));
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add();
    ent_t e;
    int k = 0;
    push_fetch(IR_ADD);
    push_step(b(I_GRB) | b(I_ROUT) | b(I_YIN), IR_ADD, 1'b1, 1'b0);
    push_step(b(I_GRC) | b(I_ROUT) | b(I_ADD) | b(I_ZIN), IR_ADD, 1'b1, 1'b0);
    push_step(b(I_ZLO) | b(I_GRA) | b(I_RIN), IR_ADD, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL add cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
  endtask

  task automatic test_mul();
    ent_t e;
    int k = 0;
    push_fetch(IR_MUL);
    push_step(b(I_GRA) | b(I_ROUT) | b(I_YIN), IR_MUL, 1'b1, 1'b0);
    push_step(b(I_GRB) | b(I_ROUT) | b(I_MUL) | b(I_ZIN), IR_MUL, 1'b1, 1'b0);
    push_step(b(I_ZLO) | b(I_LOIN), IR_MUL, 1'b1, 1'b0);
    push_step(b(I_ZHI) | b(I_HIIN), IR_MUL, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL mul cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
  endtask

  task automatic test_ld_wait();
    ent_t e;
    int k = 0;
    push_fetch(IR_LD);
    push_step(b(I_GRB) | b(I_BAOUT) | b(I_YIN), IR_LD, 1'b1, 1'b0);
    push_step(b(I_COUT) | b(I_LD) | b(I_ZIN), IR_LD, 1'b1, 1'b0);
    push_step(b(I_ZLO) | b(I_MARIN), IR_LD, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      push_step(b(I_READ) | b(I_MDRIN), IR_LD, (i == 3), 1'b0);
    push_step(b(I_MDROUT) | b(I_GRA) | b(I_RIN), IR_LD, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL ld_wait cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    int k = 0;
    push_fetch(IR_ST);
    push_step(b(I_GRB) | b(I_BAOUT) | b(I_YIN), IR_ST, 1'b1, 1'b0);
    push_step(b(I_COUT) | b(I_ST) | b(I_ZIN), IR_ST, 1'b1, 1'b0);
    push_step(b(I_ZLO) | b(I_MARIN), IR_ST, 1'b1, 1'b0);
    push_step(b(I_GRA) | b(I_ROUT) | b(I_MDRIN), IR_ST, 1'b1, 1'b0);
    push_step(b(I_MDROUT) | b(I_WRITE), IR_ST, 1'b0, 1'b0);
    push_step(b(I_MDROUT) | b(I_WRITE), IR_ST, 1'b1, 1'b0);
    push_fetch(IR_BR);
    push_step(b(I_GRA) | b(I_ROUT) | b(I_CONIN), IR_BR, 1'b1, 1'b0);
    push_step(b(I_PCOUT) | b(I_YIN), IR_BR, 1'b1, 1'b0);
    push_step(b(I_COUT) | b(I_BR) | b(I_ZIN), IR_BR, 1'b1, 1'b0);
    push_step(b(I_ZLO) | b(I_PCIN), IR_BR, 1'b1, 1'b0);
    push_fetch(IR_NOP);
    push_step(b(I_NOP), IR_NOP, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL st_br_nop cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
  endtask

  task automatic test_illegal();
    ent_t e;
    int k = 0;
    push_fetch(IR_BAD);
    push_step(b(I_ILL), IR_BAD, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL illegal cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
  endtask

  task automatic test_halt();
    ent_t e;
    int k = 0;
    push_fetch(IR_HALT);
    push_step(b(I_HALT), IR_HALT, 1'b1, 1'b0);
    push('0, IR_HALT, 1'b1, 1'b0);
    push('0, IR_HALT, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL halt cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_stop_sub();
    ent_t e;
    int k = 0;
    push_fetch(IR_SUB);
    push_step(b(I_GRB) | b(I_ROUT) | b(I_YIN), IR_SUB, 1'b1, 1'b1);
    push_step(b(I_GRC) | b(I_ROUT) | b(I_SUB) | b(I_ZIN), IR_SUB, 1'b1, 1'b1);
    push_step(b(I_ZLO) | b(I_GRA) | b(I_RIN), IR_SUB, 1'b1, 1'b1);
    push('0, IR_SUB, 1'b1, 1'b1);
    push('0, IR_SUB, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL stop_sub cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_wait_limit();
    ent_t e;
    int k = 0;
    push_step(b(I_PCOUT) | b(I_MARIN) | b(I_INCPC) | b(I_ZIN), IR_ADD, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      push_step(b(I_ZLO) | b(I_PCIN) | b(I_READ) | b(I_MDRIN), IR_ADD, 1'b0, 1'b0);
    push(b(I_MERR), IR_ADD, 1'b0, 1'b0);
    push(b(I_MERR), IR_ADD, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL wait_limit cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL wait_limit_reset: got %h expected %h", obs, vec_t'(0));
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    ent_t e;
    int k = 0;
    push_fetch(IR_SUB);
    push_step(b(I_GRB) | b(I_ROUT) | b(I_YIN), IR_SUB, 1'b1, 1'b0);
    push_step(b(I_GRC) | b(I_ROUT) | b(I_SUB) | b(I_ZIN), IR_SUB, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clock);
      checks++;
      if (obs !== e.v) begin
        failures++;
        $display("FAIL reset_mid cycle %0d: got %h expected %h", k, obs, e.v);
      end
      IR = e.ir; mem_ready = e.rdy; Stop = e.stop;
      k++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_mid_async: got %h expected %h", obs, vec_t'(0));
    end
    @(negedge clock);
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_mid_hold: got %h expected %h", obs, vec_t'(0));
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b1;
    IR        = IR_ADD;
    mem_ready = 1'b1;
    Stop      = 1'b0;
    #2 reset_n = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_ld_wait();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_stop_sub();
    test_wait_limit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit for the Mini-SRC datapath; drives the ALU's one-hot operation strobes, the IncPC input, and all bus/register enables.
- Latched IR opcode plus a step counter T0..T7 select the asserted strobes each cycle.
- Sits between the IR/memory interface and the datapath; the ALU remains purely combinational.

Parameters:
- WAIT_LIMIT, 0, maximum consecutive mem_ready-low cycles in a memory step; 0 = unlimited.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- IR  in  32  instruction register contents; opcode = IR[31:27]
- mem_ready  in  1  memory completion for the current Read/Write
- Stop  in  1  request halt at the next instruction boundary
- AND, ANDI, OR, ORI, NOT, NEG, ADD, ADDI, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, BR, LD, LDI, ST, HALT, NOP  out  1 each  ALU one-hot op strobes
- IncPC  out  1  ALU increment-B control
- PCout, PCin, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, CONin, Cout, BAout, Gra, Grb, Grc, Rin, Rout  out  1 each  datapath enables
- Run  out  1  high while sequencing
- illegal  out  1  one-cycle pulse on undefined opcode
- mem_err  out  1  sticky flag: wait limit exceeded

Behaviour:
- State = {RST, STEP(T0..T7), HALTED}, plus wait counter (clog2(WAIT_LIMIT+1) bits, minimum 1).
- reset_n low (asynchronous): state=RST, counter=0, mem_err=0. All outputs 0 while in RST.
- First clock after release: RST -> T0. Run=1 in every STEP state; Run=0 in RST and HALTED.
- Outputs are combinational decode of the registered state and IR[31:27]. Exactly one op strobe is high per cycle, at most. Strobes are high only in the step listed below.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, Read, MDRin (memory step)
  - T2: MDRout, IRin
- Execute, from T3:
  - ADD/SUB/AND/OR/SHR/SHRA/SHL/ROR/ROL: T3 Grb,Rout,Yin; T4 Grc,Rout,op,Zin; T5 Zlowout,Gra,Rin (end).
  - ADDI/ANDI/ORI: T3 Grb,Rout,Yin; T4 Cout,op,Zin; T5 Zlowout,Gra,Rin (end).
  - NOT/NEG: T3 Grb,Rout,op,Zin; T4 Zlowout,Gra,Rin (end).
  - MUL/DIV: T3 Gra,Rout,Yin; T4 Grb,Rout,op,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin (end).
  - LDI: T3 Grb,BAout,Yin; T4 Cout,LDI,Zin; T5 Zlowout,Gra,Rin (end).
  - LD: same T3-T4 with the LD strobe; T5 Zlowout,MARin; T6 Read,MDRin (memory step); T7 MDRout,Gra,Rin (end).
  - ST: T3 Grb,BAout,Yin; T4 Cout,ST,Zin; T5 Zlowout,MARin; T6 Gra,Rout,MDRin; T7 MDRout,Write (memory step, end).
  - BR: T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,BR,Zin; T6 Zlowout,PCin (end). The taken/not-taken choice is made in the ALU.
  - NOP: T3 NOP (end).
  - HALT: T3 HALT, then -> HALTED.
- Opcode map: 00000 LD, 00001 LDI, 00010 ST, 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 ROR, 01000 ROL, 01001 SHR, 01010 SHRA, 01011 SHL, 01100 ADDI, 01101 ANDI, 01110 ORI, 01111 MUL, 10000 DIV, 10001 NEG, 10010 NOT, 10011 BR, 11010 NOP, 11011 HALT.
- Any other opcode: T3 asserts illegal only, then -> T0.
- Memory steps:
  - The state holds, with all strobes held, while mem_ready=0. Advance on the edge where mem_ready=1. Counter clears on advance.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT with mem_ready still 0: set mem_err, go to HALTED.
- End step: next state is T0, or HALTED if Stop=1 on that edge. Stop is ignored mid-instruction.
- HALTED: all outputs 0 except mem_err. Exit only via reset_n.
- Reset mid-instruction or mid-wait: immediate RST. No partial strobes after reset is asserted.

Test Plan:
- Reset, then IR=ADD (0x18000000), mem_ready=1 -> T0..T5 in 6 cycles; ADD high only in T4; IncPC only in T0; Run=1 from first post-reset cycle.
- IR=MUL (0x78000000) -> 7 cycles; LOin in T5 and HIin in T6, each for one cycle; MUL high only in T4.
- IR=LD, mem_ready low for 3 cycles in T6 -> T6 lasts 4 cycles with Read/MDRin held; 11 cycles total, including 0 fetch waits.
- WAIT_LIMIT=4, mem_ready stuck 0 in T1 -> mem_err=1 after 4 wait cycles, HALTED, Run=0; reset_n low clears mem_err.
- IR opcode 11111 -> illegal pulses exactly once in T3, next state T0. IR=HALT -> HALT high in T3, then all outputs 0.
- Stop=1 raised during T3 of SUB -> SUB completes T5, then HALTED; reset_n asserted during T4 -> all outputs 0 that cycle.
